// File: rtl/fios_res_collector.sv
// fios_res_collector: gathers the s raw result words leaving the last FIOS PE
// into a local buffer, then streams them LSW-first over a valid/ready port.
// Optional feature macro: FIOS_RES_CARRY_PROP_EN (propagate word carries while
// collecting; otherwise upper raw bits must be zero and res_carry_o is tied 0).
module fios_res_collector #(
  parameter int unsigned s      = 16,
  parameter int unsigned WORD_W = 17,
  parameter int unsigned RES_W  = 34
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    RES_push_i,
  input  logic [RES_W-1:0]        RES_i,
  input  logic                    done_i,
  output logic [WORD_W-1:0]       res_word_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic                    res_last_o,
  output logic [RES_W-WORD_W-1:0] res_carry_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned CW      = $clog2(s) + 1;
  localparam int unsigned AW      = (s > 1) ? $clog2(s) : 1;
  localparam int unsigned CARRY_W = RES_W - WORD_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(s - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     wr_cnt, wr_cnt_n;
  logic [CW-1:0]     rd_cnt, rd_cnt_n;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic              take0;
  logic              err_set;
  logic [WORD_W-1:0] digit;
  logic [WORD_W-1:0] mem [s];

  // State, counters and sticky error register
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_n;
      wr_cnt <= wr_cnt_n;
      rd_cnt <= rd_cnt_n;
      err_o  <= err_o | err_set;
    end
  end

  // Next-state, write control and protocol error detection
  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    rd_cnt_n = rd_cnt;
    wr_en    = 1'b0;
    wr_idx   = '0;
    take0    = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (RES_push_i) take0 = 1'b1;
        else if (done_i) err_set = 1'b1;
      end
      COLLECT: begin
        if (RES_push_i) begin
          wr_en  = 1'b1;
          wr_idx = wr_cnt[AW-1:0];
          if (wr_cnt == LAST_IDX) begin
            wr_cnt_n = '0;
            if (done_i) begin
              state_n  = DRAIN;
              rd_cnt_n = '0;
            end else begin
              err_set = 1'b1;
              state_n = IDLE;
            end
          end else if (done_i) begin
            err_set  = 1'b1;
            state_n  = IDLE;
            wr_cnt_n = '0;
          end else begin
            wr_cnt_n = wr_cnt + CW'(1);
          end
        end else if (done_i) begin
          err_set  = 1'b1;
          state_n  = IDLE;
          wr_cnt_n = '0;
        end
      end
      DRAIN: begin
        if (res_ready_i) begin
          rd_cnt_n = rd_cnt + CW'(1);
          if (rd_cnt == LAST_IDX) begin
            state_n  = IDLE;
            rd_cnt_n = '0;
            take0    = RES_push_i;
          end
        end
        // A push is only legal when it overlaps the final handshake
        if (RES_push_i && !(res_ready_i && rd_cnt == LAST_IDX)) err_set = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Word 0 of a new result, either from IDLE or overlapping the final drain beat
    if (take0) begin
      wr_en  = 1'b1;
      wr_idx = '0;
      if (s == 1) begin
        if (done_i) begin
          state_n  = DRAIN;
          rd_cnt_n = '0;
        end else begin
          err_set = 1'b1;
          state_n = IDLE;
        end
        wr_cnt_n = '0;
      end else if (done_i) begin
        err_set  = 1'b1;
        state_n  = IDLE;
        wr_cnt_n = '0;
      end else begin
        state_n  = COLLECT;
        wr_cnt_n = CW'(1);
      end
    end
`ifndef FIOS_RES_CARRY_PROP_EN
    if (wr_en && (|RES_i[RES_W-1:WORD_W])) err_set = 1'b1;
`endif
  end

`ifdef FIOS_RES_CARRY_PROP_EN
  logic [CARRY_W-1:0] carry_reg, carry_in, carry_nxt;
  logic [RES_W:0]     sum;

  assign carry_in  = (wr_idx == '0) ? '0 : carry_reg;
  assign sum       = {1'b0, RES_i} + {{(WORD_W + 1){1'b0}}, carry_in};
  assign digit     = sum[WORD_W-1:0];
  assign carry_nxt = CARRY_W'(sum >> WORD_W);

  // Running carry between consecutive result words
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) carry_reg <= '0;
    else if (wr_en) carry_reg <= carry_nxt;
  end

  assign res_carry_o = res_last_o ? carry_reg : '0;
`else
  assign digit       = RES_i[WORD_W-1:0];
  assign res_carry_o = '0;
`endif

  // Result buffer; contents are don't-care out of reset
  always_ff @(posedge clock_i) begin
    if (wr_en) mem[wr_idx] <= digit;
  end

  assign res_valid_o = (state == DRAIN);
  assign res_word_o  = res_valid_o ? mem[rd_cnt[AW-1:0]] : '0;
  assign res_last_o  = res_valid_o && (rd_cnt == LAST_IDX);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_fios_res_collector.sv
// Directed testbench for fios_res_collector with s=4, WORD_W=17, RES_W=34.
module tb_fios_res_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [33:0] res = '0;
  logic        done = 1'b0;
  logic        ready = 1'b0;
  logic [16:0] word;
  logic        valid, last, busy, err;
  logic [16:0] carry;

  int checks = 0;
  int passed = 0;

  fios_res_collector #(.s(4), .WORD_W(17), .RES_W(34)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .RES_push_i(push), .RES_i(res),
    .done_i(done), .res_word_o(word), .res_valid_o(valid),
    .res_ready_i(ready), .res_last_o(last), .res_carry_o(carry),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0; done = 1'b0; ready = 1'b0; res = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_seq(input logic [33:0] w0, input logic [33:0] w1,
                          input logic [33:0] w2, input logic [33:0] w3);
    logic [33:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; res = w[i]; done = (i == 3);
      tick();
    end
    push = 1'b0; done = 1'b0; res = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, last, busy, err} !== 4'b0 || word !== 17'h0 || carry !== 17'h0)
      $display("FAIL reset_outputs: got valid=%0b last=%0b busy=%0b err=%0b word=%h carry=%h want all 0",
               valid, last, busy, err, word, carry);
    else passed++;
    do_reset();
  endtask

  task automatic test_basic();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; res = 34'(i + 1); done = (i == 3);
      tick();
      if (i < 3) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1)
          $display("FAIL basic_collect%0d: got valid=%0b busy=%0b want 0 1", i, valid, busy);
        else passed++;
      end
    end
    push = 1'b0; done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || word !== 17'(k + 1) || last !== (k == 3))
        $display("FAIL basic_word%0d: got valid=%0b word=%h last=%0b want 1 %h %0b",
                 k, valid, word, last, 17'(k + 1), (k == 3));
      else passed++;
      tick();
    end
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL basic_end: got valid=%0b busy=%0b err=%0b want 0 0 0", valid, busy, err);
    else passed++;
  endtask

  task automatic test_carry();
    logic [16:0] exp [4];
    logic        exp_err;
`ifdef FIOS_RES_CARRY_PROP_EN
    exp[0] = 17'h0; exp[1] = 17'h0; exp[2] = 17'h1; exp[3] = 17'h0; exp_err = 1'b0;
`else
    exp[0] = 17'h0; exp[1] = 17'h1FFFF; exp[2] = 17'h0; exp[3] = 17'h0; exp_err = 1'b1;
`endif
    do_reset();
    push_seq(34'h20000, 34'h1FFFF, 34'h0, 34'h0);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (word !== exp[k] || last !== (k == 3) || (k == 3 && carry !== 17'h0))
        $display("FAIL carry_word%0d: got word=%h last=%0b carry=%h want %h %0b 0",
                 k, word, last, carry, exp[k], (k == 3));
      else passed++;
      tick();
    end
    checks++;
    if (err !== exp_err) $display("FAIL carry_err: got %0b want %0b", err, exp_err);
    else passed++;
    do_reset();
  endtask

  task automatic test_stall();
    logic [16:0] exp [4];
    logic        rdy [6];
    int          idx;
    exp[0] = 17'h11; exp[1] = 17'h22; exp[2] = 17'h33; exp[3] = 17'h44;
    rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 1; rdy[5] = 1;
    ready = 1'b0;
    push_seq(34'h11, 34'h22, 34'h33, 34'h44);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      ready = rdy[c];
      checks++;
      if (valid !== 1'b1 || word !== exp[idx] || last !== (idx == 3))
        $display("FAIL stall_cycle%0d: got valid=%0b word=%h last=%0b want 1 %h %0b",
                 c, valid, word, last, exp[idx], (idx == 3));
      else passed++;
      if (rdy[c]) idx++;
      tick();
    end
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_end: got valid=%0b busy=%0b want 0 0", valid, busy);
    else passed++;
  endtask

  task automatic test_errors();
    logic [16:0] exp [4];
    exp[0] = 17'h5; exp[1] = 17'h6; exp[2] = 17'h7; exp[3] = 17'h8;
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; res = 34'(i + 1); done = (i == 2);
      tick();
    end
    push = 1'b0; done = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL early_done: got err=%0b busy=%0b valid=%0b want 1 0 0", err, busy, valid);
    else passed++;
    tick();
    tick();
    checks++;
    if (valid !== 1'b0) $display("FAIL early_done_novalid: got %0b want 0", valid);
    else passed++;

    do_reset();
    ready = 1'b0;
    push_seq(34'h5, 34'h6, 34'h7, 34'h8);
    tick();
    push = 1'b1; res = 34'h55;
    tick();
    push = 1'b0; res = '0;
    checks++;
    if (err !== 1'b1 || valid !== 1'b1 || word !== exp[0])
      $display("FAIL drain_push: got err=%0b valid=%0b word=%h want 1 1 %h", err, valid, word, exp[0]);
    else passed++;
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || word !== exp[k] || last !== (k == 3))
        $display("FAIL drain_intact%0d: got valid=%0b word=%h last=%0b want 1 %h %0b",
                 k, valid, word, last, exp[k], (k == 3));
      else passed++;
      tick();
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL drain_push_end: got busy=%0b want 0", busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [16:0] a [4];
    logic [16:0] b [4];
    a[0] = 17'hA0; a[1] = 17'hA1; a[2] = 17'hA2; a[3] = 17'hA3;
    b[0] = 17'hB0; b[1] = 17'hB1; b[2] = 17'hB2; b[3] = 17'hB3;
    do_reset();
    ready = 1'b1;
    push_seq(34'hA0, 34'hA1, 34'hA2, 34'hA3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (word !== a[k] || last !== (k == 3))
        $display("FAIL b2b_a%0d: got word=%h last=%0b want %h %0b", k, word, last, a[k], (k == 3));
      else passed++;
      if (k == 3) begin
        push = 1'b1; res = 34'hB0;
      end
      tick();
    end
    push = 1'b0; res = '0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0)
      $display("FAIL b2b_overlap: got busy=%0b valid=%0b want 1 0", busy, valid);
    else passed++;
    for (int i = 1; i < 4; i++) begin
      push = 1'b1; res = 34'(b[i]); done = (i == 3);
      tick();
    end
    push = 1'b0; done = 1'b0; res = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || word !== b[k] || last !== (k == 3))
        $display("FAIL b2b_b%0d: got valid=%0b word=%h last=%0b want 1 %h %0b",
                 k, valid, word, last, b[k], (k == 3));
      else passed++;
      tick();
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_end: got err=%0b busy=%0b want 0 0", err, busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b1;
    push = 1'b1; res = 34'h9;
    tick();
    res = 34'hA;
    tick();
    push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_collect: got busy=%0b valid=%0b err=%0b want 0 0 0", busy, valid, err);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();

    ready = 1'b0;
    push_seq(34'h1, 34'h2, 34'h3, 34'h4);
    checks++;
    if (valid !== 1'b1) $display("FAIL reset_drain_pre: got valid=%0b want 1", valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || word !== 17'h0 || last !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_drain: got valid=%0b word=%h last=%0b busy=%0b want 0 0 0 0",
               valid, word, last, busy);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();

    ready = 1'b1;
    push_seq(34'h31, 34'h32, 34'h33, 34'h34);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || word !== 17'(8'h31 + k) || last !== (k == 3))
        $display("FAIL reset_clean%0d: got valid=%0b word=%h last=%0b want 1 %h %0b",
                 k, valid, word, last, 17'(8'h31 + k), (k == 3));
      else passed++;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_clean_end: got busy=%0b err=%0b want 0 0", busy, err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_stall();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
